// File: rtl/updown_counter_pkg.sv
// Shared constants for the parametrised up/down counter family.
package updown_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : updown_counter_pkg

// File: rtl/updown_counter_next.sv
// Combinational next-count and terminal-count event logic for updown_counter_param.
module updown_counter_next
    import updown_counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             en_i,
    input  logic             sel_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] count_d_o,
    output logic             tc_d_o
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);

    function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] value);
        if (value > MAX_C) begin
            return MAX_C;
        end else begin
            return value;
        end
    endfunction

    // Boundaries are compared against MAX_C explicitly so non-power-of-two ranges wrap correctly.
    always_comb begin
        count_d_o = count_i;
        tc_d_o    = 1'b0;
        if (load_i) begin
            count_d_o = clamp_to_max(load_value_i);
        end else if (en_i) begin
            if (sel_i == DIR_UP) begin
                if (count_i >= MAX_C) begin
                    tc_d_o    = 1'b1;
                    count_d_o = (mode_i == MODE_SAT) ? MAX_C : ZERO_C;
                end else begin
                    count_d_o = count_i + ONE_C;
                end
            end else begin
                if (count_i == ZERO_C) begin
                    tc_d_o    = 1'b1;
                    count_d_o = (mode_i == MODE_SAT) ? ZERO_C : MAX_C;
                end else begin
                    count_d_o = count_i - ONE_C;
                end
            end
        end else begin
            count_d_o = count_i;
            tc_d_o    = 1'b0;
        end
    end

endmodule : updown_counter_next

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap/saturate, load, boundary flags and tc pulse.
// Optional sticky ovf/udf status (with status_clr) when UPDOWN_COUNTER_STATUS_EN is defined.
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int          WIDTH       = 4,
    parameter int unsigned MAX_COUNT   = (2 ** WIDTH) - 1,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sel,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             tc
`ifdef UPDOWN_COUNTER_STATUS_EN
   ,input  logic             status_clr,
    output logic             ovf,
    output logic             udf
`endif
);

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;

    updown_counter_next #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_next (
        .count_i      (count_q),
        .en_i         (en),
        .sel_i        (sel),
        .mode_i       (mode),
        .load_i       (load),
        .load_value_i (load_value),
        .count_d_o    (count_d),
        .tc_d_o       (tc_d)
    );

    // Count and terminal-count pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RESET_C;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign at_max = (count_q == MAX_C);
    assign at_min = (count_q == {WIDTH{1'b0}});

`ifdef UPDOWN_COUNTER_STATUS_EN
    logic ovf_q;
    logic ovf_d;
    logic udf_q;
    logic udf_d;

    // A boundary event in the same cycle as status_clr keeps its flag set.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (tc_d && (sel == DIR_UP)) begin
            ovf_d = 1'b1;
        end else if (status_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (tc_d && (sel == DIR_DOWN)) begin
            udf_d = 1'b1;
        end else if (status_clr) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    // Sticky overflow/underflow status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

endmodule : updown_counter_param
